// File: rtl/midi_note_tracker_pkg.sv
// Shared MIDI constants and types for the note tracker and its held-key stack.
package gb_midi_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic {
        WAIT_KEY,
        WAIT_VEL
    } parse_state_t;

    typedef enum logic [1:0] {
        RS_NONE,
        RS_OFF,
        RS_ON
    } run_status_t;

    typedef struct packed {
        logic       valid;
        logic [6:0] key;
        logic [6:0] vel;
    } stack_entry_t;

endpackage

// File: rtl/note_stack.sv
// Last-note-priority held-key stack, entry 0 is the top; push dedupes and drops the oldest when full.
// Single-cycle update, never stalls; top_key/top_vel/empty show the post-operation top for this cycle.
module note_stack
    import gb_midi_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               remove,
    input  logic [6:0]                         key,
    input  logic [6:0]                         vel,
    output logic [6:0]                         top_key,
    output logic [6:0]                         top_vel,
    output logic                               empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    stack_entry_t ent [STACK_DEPTH];
    stack_entry_t ext [STACK_DEPTH+1];
    stack_entry_t rem [STACK_DEPTH];
    stack_entry_t nxt [STACK_DEPTH];
    logic          found;
    logic [CW-1:0] rem_count;
    logic [CW-1:0] nxt_count;

    always_comb begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            ext[i] = ent[i];
        end
        ext[STACK_DEPTH] = '0;

        // Entries are unique, so everything at and below the single match shifts up by one.
        found = 1'b0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (ext[i].valid && ext[i].key == key) begin
                found = 1'b1;
            end
            rem[i] = found ? ext[i+1] : ext[i];
        end
        rem_count = count - CW'(found);

        nxt       = ent;
        nxt_count = count;
        if (push) begin
            nxt[0] = '{valid: 1'b1, key: key, vel: vel};
            for (int i = 1; i < STACK_DEPTH; i++) begin
                nxt[i] = rem[i-1];
            end
            nxt_count = (rem_count == CW'(STACK_DEPTH)) ? rem_count : rem_count + CW'(1);
        end else if (remove) begin
            nxt       = rem;
            nxt_count = rem_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ent[i] <= '0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ent[i] <= nxt[i];
            end
            count <= nxt_count;
        end
    end

    assign top_key = nxt[0].key;
    assign top_vel = nxt[0].vel;
    assign empty   = !nxt[0].valid;

endmodule

// File: rtl/midi_note_tracker.sv
// Single-channel MIDI parser with running status driving a last-note-priority key stack.
// Outputs registered at the edge that samples the completing byte; accepts a byte every cycle, no backpressure.
module midi_note_tracker
    import gb_midi_pkg::*;
#(
    parameter int CHANNEL     = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         midi_byte,
    input  logic                               midi_valid,
    output logic                               note_on,
    output logic [6:0]                         note_start,
    output logic [6:0]                         vel_start,
    output logic                               note_repeat,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count
);

    localparam logic [3:0] CH = 4'(CHANNEL);

    parse_state_t state_q, state_d;
    run_status_t  rs_q, rs_d;
    logic [6:0]   key_q, key_d;
    logic         push, remove;
    logic [6:0]   top_key, top_vel;
    logic         empty;

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        key_d   = key_q;
        push    = 1'b0;
        remove  = 1'b0;
        // Realtime bytes fall through untouched, even in the middle of a message.
        if (midi_valid && midi_byte < REALTIME_MIN) begin
            if (midi_byte[7]) begin
                state_d = WAIT_KEY;
                if (midi_byte[3:0] == CH && midi_byte[7:4] == NOTE_OFF) begin
                    rs_d = RS_OFF;
                end else if (midi_byte[3:0] == CH && midi_byte[7:4] == NOTE_ON) begin
                    rs_d = RS_ON;
                end else begin
                    rs_d = RS_NONE;
                end
            end else if (rs_q != RS_NONE) begin
                if (state_q == WAIT_KEY) begin
                    key_d   = midi_byte[6:0];
                    state_d = WAIT_VEL;
                end else begin
                    state_d = WAIT_KEY;
                    if (rs_q == RS_ON && midi_byte[6:0] != 7'd0) begin
                        push = 1'b1;
                    end else begin
                        remove = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_KEY;
            rs_q    <= RS_NONE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            key_q   <= key_d;
        end
    end

    note_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .remove  (remove),
        .key     (key_q),
        .vel     (midi_byte[6:0]),
        .top_key (top_key),
        .top_vel (top_vel),
        .empty   (empty),
        .count   (stack_count)
    );

    // On an empty stack the last key/velocity are held so the envelope can release cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_on     <= 1'b0;
            note_start  <= '0;
            vel_start   <= '0;
            note_repeat <= 1'b0;
        end else begin
            note_repeat <= push && note_on && (note_start == key_q);
            if (push || remove) begin
                note_on <= !empty;
                if (!empty) begin
                    note_start <= top_key;
                    vel_start  <= top_vel;
                end
            end
        end
    end

endmodule

// File: doc/midi_note_tracker.md
# midi_note_tracker

Single-channel MIDI note tracker feeding the per-channel envelope stage in the Game Boy MIDI core. It parses a raw MIDI byte stream, filters one MIDI channel and keeps a last-note-priority stack of held keys. It presents the active key and its velocity as `note_on`, `note_start`, `vel_start`, plus a `note_repeat` pulse. The envelope stage consumes these ports directly.

## Interface
- `CHANNEL`, default 0: MIDI channel (0–15) accepted; all other channels ignored.
- `STACK_DEPTH`, default 4: held-key stack entries (2–8).
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `midi_byte`  in  8  received MIDI byte.
- `midi_valid`  in  1  `midi_byte` valid this cycle; may be high every cycle.
- `note_on`  out  1  at least one key held.
- `note_start`  out  7  active (top-of-stack) key.
- `vel_start`  out  7  velocity stored with active key.
- `note_repeat`  out  1  one-cycle pulse: active key re-struck while already active.
- `stack_count`  out  $clog2(STACK_DEPTH+1)  number of held keys.

## Operation
- **Running status** `rs`: NONE / OFF / ON.
- **Parser states**: WAIT_KEY, WAIT_VEL. A key register holds the data byte.
- **Status byte**, bit7=1, handled by class:
  - `F8`–`FF` (realtime): ignored; no change to state or `rs`.
  - `8n` with n==CHANNEL: `rs`=OFF, go to WAIT_KEY.
  - `9n` with n==CHANNEL: `rs`=ON, go to WAIT_KEY.
  - Any other status, including `F0`–`F7`: `rs`=NONE, go to WAIT_KEY. A partial message in WAIT_VEL is discarded.
- **Data byte**, bit7=0:
  - `rs`=NONE: ignored.
  - In WAIT_KEY: latch key, go to WAIT_VEL.
  - In WAIT_VEL: message complete, go to WAIT_KEY. Running status allows further key/vel pairs without a new status byte.
- **Message classification**: ON with vel=0 is an OFF event. ON with vel>0 is an ON event. OFF ignores its velocity.
- **ON event(k,v)**:
  - If k is already in the stack, remove it and compact.
  - Push (k,v) on top.
  - If full, the bottom (oldest) entry is dropped; count stays at STACK_DEPTH.
  - Outputs take top: `note_on`=1, `note_start`=k, `vel_start`=v.
  - `note_repeat`=1 iff `note_on` was 1 and the previous `note_start`==k.
- **OFF event(k)**:
  - k absent: no change.
  - k below top: remove and compact; outputs unchanged.
  - k on top: pop. If entries remain, `note_start`/`vel_start` take the new top's stored key/velocity and `note_on` stays 1 (legato; no `note_repeat`). If the stack is empty, `note_on`=0 and `note_start`/`vel_start` hold their last values.

## Timing
- **Reset values**: `note_on`=0, `note_start`=0, `vel_start`=0, `note_repeat`=0, `stack_count`=0. Also `rs`=NONE, state=WAIT_KEY, all stack entries invalid.
- Reset dominates `midi_valid` in the same cycle. Reset mid-message discards the partial message.
- **Latency**: the completing velocity byte is sampled at edge N. Stack and all outputs are updated at edge N (visible in cycle N+1). All outputs are registered.
- `note_repeat` is high for exactly one cycle, aligned with the output update. It is never high while `note_on`=0.
- Back-to-back bytes on every cycle are accepted. The stack search, remove, compact and push complete in one cycle, so no stall and no backpressure.
- A status byte and its completion cannot coincide (one byte per cycle), so there are no same-cycle event conflicts.

## Structure
- Package `gb_midi_pkg`: status nibble constants `NOTE_OFF`=4'h8 and `NOTE_ON`=4'h9, realtime threshold 8'hF8, parser-state enum, running-status enum, stack entry type {valid, key[6:0], vel[6:0]}.
- Sub-module `note_stack`: parameterised by STACK_DEPTH. Provides push(k,v) with dedupe and oldest-drop, remove(k) with compaction, and top/count/empty outputs, all in a single cycle. The parent holds the parser and output registers.

## Test plan
- Reset, then `90 3C 64` (CHANNEL=0) → next cycle `note_on`=1, `note_start`=0x3C, `vel_start`=0x64, `note_repeat`=0, `stack_count`=1.
- `90 3C 64 40 50 80 40 00` → after the second ON, active=0x40/0x50. After the OFF 0x40, active=0x3C/0x64 with `note_on` held 1 throughout and no `note_repeat`.
- `90 3C 64 3C 70` (running status) → second completion gives `note_repeat` pulse of 1 cycle, `vel_start`=0x70, `stack_count`=1.
- STACK_DEPTH=4, ON keys 1,2,3,4,5, then OFF 5,4,3,2 → `stack_count` saturates at 4. After the last OFF, `note_on`=0 (key 1 dropped). `note_start` holds 2.
- `91 3C 64` (other channel), `90 3C F8 64` (realtime inside message), `90 3C B0 64` (status abort) → first: no change; second: ON 0x3C/0x64; third: no event, `rs`=NONE.
- `90 3C 64`, then `90 3C 00` → `note_on`=0. Assert `reset` during `90 3C` partial, then send `64` → no event, all outputs at reset values.
